// File: rtl/muldiv_pkg.sv
// Shared encodings and sign helpers for the iterative multiply/divide unit.
// Helpers work on MAX_DW bits; callers extend and truncate with size casts (WIDTH <= 64).
package muldiv_pkg;

    localparam int MAX_DW = 128;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic [MAX_DW-1:0] negate(input logic [MAX_DW-1:0] x);
        return ~x + MAX_DW'(1);
    endfunction

    // Two's-complement negation is width-agnostic once truncated, so one helper
    // serves magnitudes, products, quotients and remainders alike.
    function automatic logic [MAX_DW-1:0] cond_negate(input logic [MAX_DW-1:0] x,
                                                      input logic              neg);
        return neg ? negate(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with the architectural HI/LO pair.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dzo_q, dzo_d;

    logic             sgn_op, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_sh, trial;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    // Datapath registers carry no reset: they are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        acc_q     <= acc_d;
        mcand_q   <= mcand_d;
        b_q       <= b_d;
        quo_q     <= quo_d;
        rem_q     <= rem_d;
        a_raw_q   <= a_raw_d;
        is_div_q  <= is_div_d;
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
        dz_q      <= dz_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC: begin
                if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div_q && (b_q >> 1) == '0) state_d = FINISH;
`endif
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        div_by_zero = dzo_q;
        hi          = hi_q;
        lo          = lo_q;
    end

    always_comb begin
        sgn_op = (op == OP_MULT) || (op == OP_DIV);
        sa     = sgn_op & src_a[WIDTH-1];
        sb     = sgn_op & src_b[WIDTH-1];
        mag_a  = WIDTH'(cond_negate(MAX_DW'(src_a), sa));
        mag_b  = WIDTH'(cond_negate(MAX_DW'(src_b), sb));

        // Restoring step: bring in the next dividend bit and try the subtract.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, b_q};

        prod_fix = PW'(cond_negate(MAX_DW'(acc_q), neg_q));
        quo_fix  = WIDTH'(cond_negate(MAX_DW'(quo_q), neg_q));
        rem_fix  = WIDTH'(cond_negate(MAX_DW'(rem_q), neg_rem_q));
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        b_d       = b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = (state_q == FINISH);
        dzo_d     = (state_q == FINISH) && dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = PW'(mag_a);
                    b_d       = mag_b;
                    quo_d     = mag_a;
                    rem_d     = '0;
                    a_raw_d   = src_a;
                    is_div_d  = op[1];
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    dz_d      = op[1] && (src_b == '0);
                end else begin
                    if (hi_we) hi_d = wr_data;
                    if (lo_we) lo_d = wr_data;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                end
            end
            FINISH: begin
                if (is_div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[PW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model plus directed literals.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b, wr_data;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wr_data(wr_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Architectural result {div_by_zero, hi, lo} straight from the arithmetic definition.
    function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                p = {a % b, a / b};
            end
        endcase
        return {1'b0, p};
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] mag;
        int n;
        bit eo;
        eo = 0;
`ifdef MULDIV_EARLY_OUT_EN
        eo = 1;
`endif
        mag = (o == 2'b00 && b[31]) ? (~b + 32'd1) : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
        if (eo && !o[1]) return ((n < 1) ? 1 : n) + 1;
        return W + 1;
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [64:0] m_pend;
    int          m_left;
    logic        m_done, m_dz;

    always @(posedge clk) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_pend <= ref_result(op, src_a, src_b);
                    m_left <= ref_lat(op, src_b);
                end else begin
                    if (hi_we) m_hi <= wr_data;
                    if (lo_we) m_lo <= wr_data;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_dz   <= m_pend[64];
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 64'(busy), 64'(m_left != 0));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_dz",   64'(div_by_zero), 64'(m_dz));
            check("cyc_hi",   64'(hi), 64'(m_hi));
            check("cyc_lo",   64'(lo), 64'(m_lo));
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
    endtask

    // Iteration k runs after edge k-1 following acceptance; intf_k injects a
    // start plus MTHI/MTLO that must be ignored because the unit is busy.
    task automatic wait_done(input int intf_k, output bit seen, output int lat);
        seen = 0;
        lat  = -1;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            src_a = ~src_a; src_b = ~src_b;
            if (k == intf_k) begin
                start = 1'b1; op = 2'b11; src_a = 32'h99; src_b = 32'h3;
                hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h77;
            end
            if (done) begin
                seen = 1;
                lat  = k - 1;
            end
        end
        check("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int lat_fixed, input int lat_eo,
                          input int intf_k);
        bit seen;
        int lat, elat;
        elat = lat_fixed;
`ifdef MULDIV_EARLY_OUT_EN
        elat = lat_eo;
`endif
        start_op(o, a, b);
        wait_done(intf_k, seen, lat);
        check({nm, "_hi"},  64'(hi), 64'(ehi));
        check({nm, "_lo"},  64'(lo), 64'(elo));
        check({nm, "_dz"},  64'(div_by_zero), 64'(edz));
        check({nm, "_lat"}, 64'(lat), 64'(elat));
        @(negedge clk);
        check({nm, "_done_pulse"}, 64'(done), 64'd0);
        check({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit seen;
        int lat, ndone, intf;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_hi",   64'(hi), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz",   64'(div_by_zero), 64'd0);

        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 4, 0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 33, 0);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33, 0);
        run_op("divu",      2'b11, 32'd7,         32'd2,        32'd1,         32'd3,         1'b0, 33, 33, 0);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 33, 33, 0);
        run_op("divu_z",    2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 33, 33, 0);
        run_op("div_z_neg", 2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 33, 33, 0);
        run_op("div_mix",   2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 1'b0, 33, 33, 0);

        intf = 10;
`ifdef MULDIV_EARLY_OUT_EN
        intf = 2;
`endif
        run_op("busy_ign",  2'b01, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 33, 4, intf);

        start_op(2'b00, 32'd9, 32'd9);
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (k == 5);
            if (done) ndone++;
            if (k == 6) begin
                check("midrst_busy", 64'(busy), 64'd0);
                check("midrst_hi",   64'(hi), 64'd0);
                check("midrst_lo",   64'(lo), 64'd0);
            end
        end
        check("midrst_no_done", 64'(ndone), 64'd0);

        hi_we = 1'b1; wr_data = 32'hA5;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'hA5);
        lo_we = 1'b1; wr_data = 32'h5A;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'h5A);
        check("mtlo_hi_kept", 64'(hi), 64'hA5);

        start_op(2'b01, 32'd2, 32'd3);
        hi_we = 1'b1; wr_data = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("collide_hi",   64'(hi), 64'hA5);
        check("collide_busy", 64'(busy), 64'd1);
        wait_done(0, seen, lat);
        check("collide_lo", 64'(lo), 64'd6);
        @(negedge clk);

        run_op("eo_3x2", 2'b01, 32'd3, 32'd2, 32'd0, 32'd6, 1'b0, 33, 3, 0);
        run_op("eo_3x0", 2'b01, 32'd3, 32'd0, 32'd0, 32'd0, 1'b0, 33, 2, 0);
        run_op("eo_divu", 2'b11, 32'd3, 32'd2, 32'd1, 32'd1, 1'b0, 33, 33, 0);

        for (int i = 0; i < 8; i++) begin
            start_op(2'(i % 4), $urandom, (i == 6) ? 32'd0 : $urandom_range(32'hFFFF, 0) << (i % 3) * 8);
            wait_done(0, seen, lat);
            @(negedge clk);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
